// File: rtl/ppwm_mc.sv
// ppwm_mc: multi-channel programmable PWM generator.
// One shared period counter (edge- or center-aligned) drives NUM_CH outputs. Settings arrive
// as serial frames on data_i, land in shadow registers and go live only at a period wrap.
module ppwm_mc #(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned COUNTER_WIDTH = 10,
    parameter int unsigned ADDR_WIDTH    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_i,
    output logic [NUM_CH-1:0] pwm_o,
    output logic              period_start_o,
    output logic              cfg_valid_o,
    output logic              cfg_err_o
);

    localparam int unsigned W        = COUNTER_WIDTH;
    localparam int unsigned A        = ADDR_WIDTH;
    localparam int unsigned FrameLen = A + 2 + W;
    localparam int unsigned BitCntW  = $clog2(FrameLen + 1);

    localparam logic [BitCntW-1:0] LastBit = BitCntW'(FrameLen - 1);
    localparam logic [BitCntW-1:0] BitOne  = BitCntW'(1);
    localparam logic [W-1:0]       One     = W'(1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StWrite = 2'd2;

    localparam logic [1:0] FldCmp    = 2'b00;
    localparam logic [1:0] FldCtrl   = 2'b01;
    localparam logic [1:0] FldPeriod = 2'b10;

    // Receiver state
    logic [1:0]          state;
    logic [BitCntW-1:0]  bit_cnt;
    logic [FrameLen-1:0] shift;

    // Decoded frame
    logic [A-1:0]  frm_addr;
    logic [1:0]    frm_field;
    logic [W-1:0]  frm_data;
    logic [31:0]   addr_ext;
    logic          is_write;
    logic          addr_bad;

    // Shadow registers
    logic [NUM_CH-1:0][W-1:0] cmp_sh;
    logic [NUM_CH-1:0]        en_sh;
    logic [NUM_CH-1:0]        pol_sh;
    logic [W-1:0]             period_sh;
    logic                     center_sh;

    // Active registers
    logic [NUM_CH-1:0][W-1:0] cmp_act;
    logic [NUM_CH-1:0]        en_act;
    logic [NUM_CH-1:0]        pol_act;
    logic [W-1:0]             period_act;
    logic                     center_act;

    // Period counter
    logic [W-1:0]      cnt;
    logic [W-1:0]      cnt_d;
    logic              dir_up;
    logic              dir_up_d;
    logic              wrap;
    logic [NUM_CH-1:0] pwm_d;

    assign frm_addr  = shift[FrameLen-1 -: A];
    assign frm_field = shift[W+1:W];
    assign frm_data  = shift[W-1:0];
    assign addr_ext  = 32'(frm_addr);
    assign is_write  = (state == StWrite);
    // Only per-channel fields carry a meaningful address
    assign addr_bad  = ~frm_field[1] && (addr_ext >= NUM_CH);

    // Serial frame receiver: start bit, then FrameLen payload bits MSB first, then a write cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= StIdle;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (data_i) begin
                        state   <= StShift;
                        bit_cnt <= '0;
                    end
                end
                StShift: begin
                    shift   <= {shift[FrameLen-2:0], data_i};
                    bit_cnt <= bit_cnt + BitOne;
                    if (bit_cnt == LastBit) begin
                        state <= StWrite;
                    end
                end
                StWrite: state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

    // Status pulses for the completed frame
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_valid_o <= 1'b0;
            cfg_err_o   <= 1'b0;
        end else begin
            cfg_valid_o <= is_write & ~addr_bad;
            cfg_err_o   <= is_write & addr_bad;
        end
    end

    // Shadow register writes from accepted frames
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_sh    <= '0;
            en_sh     <= '0;
            pol_sh    <= '0;
            period_sh <= '1;
            center_sh <= 1'b0;
        end else if (is_write && !addr_bad) begin
            case (frm_field)
                FldCmp: begin
                    for (int i = 0; i < int'(NUM_CH); i++) begin
                        if (addr_ext == 32'(i)) begin
                            cmp_sh[i] <= frm_data;
                        end
                    end
                end
                FldCtrl: begin
                    for (int i = 0; i < int'(NUM_CH); i++) begin
                        if (addr_ext == 32'(i)) begin
                            en_sh[i]  <= frm_data[0];
                            pol_sh[i] <= frm_data[1];
                        end
                    end
                end
                FldPeriod: period_sh <= frm_data;
                default:   center_sh <= frm_data[0];
            endcase
        end
    end

    // Next counter value; a wrap is any step that lands back on 0
    always_comb begin
        cnt_d    = cnt;
        dir_up_d = dir_up;
        if (!center_act) begin
            cnt_d = (cnt >= period_act) ? '0 : cnt + One;
        end else if (dir_up) begin
            if (cnt < period_act) begin
                cnt_d = cnt + One;
            end else if (cnt == '0) begin
                cnt_d = '0;  // P=0: every cycle is a period start
            end else begin
                cnt_d    = cnt - One;
                dir_up_d = 1'b0;
            end
        end else begin
            cnt_d = (cnt == '0) ? '0 : cnt - One;
        end
        wrap = (cnt_d == '0);
        if (wrap) begin
            dir_up_d = 1'b1;
        end
    end

    // Period counter and direction
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            dir_up <= 1'b1;
        end else begin
            cnt    <= cnt_d;
            dir_up <= dir_up_d;
        end
    end

    // Active registers follow the shadow copy only at a wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_act    <= '0;
            en_act     <= '0;
            pol_act    <= '0;
            period_act <= '1;
            center_act <= 1'b0;
        end else if (wrap) begin
            cmp_act    <= cmp_sh;
            en_act     <= en_sh;
            pol_act    <= pol_sh;
            period_act <= period_sh;
            center_act <= center_sh;
        end
    end

    // Per-channel compare and polarity
    always_comb begin
        pwm_d = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            pwm_d[i] = en_act[i] ? ((cnt < cmp_act[i]) ^ pol_act[i]) : pol_act[i];
        end
    end

    // Registered outputs, one cycle behind cnt
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_o          <= '0;
            period_start_o <= 1'b0;
        end else begin
            pwm_o          <= pwm_d;
            period_start_o <= (cnt == '0);
        end
    end

endmodule

// File: tb/tb_ppwm_mc.sv
// tb_ppwm_mc: directed bench for ppwm_mc (W=8; a 4-channel and a 3-channel instance).
module tb_ppwm_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       data4;
    logic       data3;
    logic [3:0] pwm4;
    logic       ps4, val4, err4;
    logic [2:0] pwm3;
    logic       ps3, val3, err3;

    int tests = 0;
    int fails = 0;

    logic [63:0] cap_ch [4];
    logic [63:0] cap_ps;

    ppwm_mc #(.NUM_CH(4), .COUNTER_WIDTH(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .data_i         (data4),
        .pwm_o          (pwm4),
        .period_start_o (ps4),
        .cfg_valid_o    (val4),
        .cfg_err_o      (err4)
    );

    ppwm_mc #(.NUM_CH(3), .COUNTER_WIDTH(8)) dut3 (
        .clk            (clk),
        .rst            (rst),
        .data_i         (data3),
        .pwm_o          (pwm3),
        .period_start_o (ps3),
        .cfg_valid_o    (val3),
        .cfg_err_o      (err3)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Shift one frame out, then check {cfg_valid, cfg_err} right after the write edge
    task automatic send(input int tgt, input logic [1:0] addr, input logic [1:0] field,
                        input logic [7:0] data, input logic [1:0] exp_st, input string tag);
        logic [12:0] frame;
        frame = {1'b1, addr, field, data};
        for (int i = 12; i >= 0; i--) begin
            if (tgt == 3) data3 = frame[i];
            else data4 = frame[i];
            step();
        end
        data3 = 1'b0;
        data4 = 1'b0;
        step();
        if (tgt == 3) check(tag, {62'd0, val3, err3}, {62'd0, exp_st});
        else check(tag, {62'd0, val4, err4}, {62'd0, exp_st});
    endtask

    task automatic wait_ps(input int tgt, input int limit);
        int n;
        n = 0;
        while (((tgt == 3) ? ps3 : ps4) !== 1'b1 && n < limit) begin
            step();
            n++;
        end
        if (((tgt == 3) ? ps3 : ps4) !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL wait_ps: no period start within %0d cycles", limit);
        end
    endtask

    // Land on the start of a period that began after everything written so far
    task automatic sync(input int tgt, input int limit);
        wait_ps(tgt, limit);
        step();
        wait_ps(tgt, limit);
    endtask

    // Record len cycles, first cycle ends up as the MSB
    task automatic capture(input int tgt, input int len);
        logic [3:0] p;
        logic       s;
        for (int c = 0; c < 4; c++) cap_ch[c] = '0;
        cap_ps = '0;
        for (int i = 0; i < len; i++) begin
            p = (tgt == 3) ? {1'b0, pwm3} : pwm4;
            s = (tgt == 3) ? ps3 : ps4;
            for (int c = 0; c < 4; c++) cap_ch[c] = {cap_ch[c][62:0], p[c]};
            cap_ps = {cap_ps[62:0], s};
            step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic [3:0] pw_or;

        // Reset
        rst   = 1'b1;
        data4 = 1'b0;
        data3 = 1'b0;
        repeat (3) step();
        check("reset_pwm", {60'd0, pwm4}, 64'd0);
        check("reset_flags", {61'd0, ps4, val4, err4}, 64'd0);
        check("reset_pwm3", {61'd0, pwm3}, 64'd0);
        rst = 1'b0;
        step();
        check("first_ps", {63'd0, ps4}, 64'd1);
        n = 0;
        pw_or = '0;
        do begin
            step();
            n++;
            pw_or |= pwm4;
        end while (ps4 !== 1'b1 && n < 300);
        check("idle_period", 64'(n), 64'd256);
        check("idle_pwm", {60'd0, pw_or}, 64'd0);

        // Edge PWM: P=9, ch0 cmp=3 en=1
        send(4, 2'd0, 2'b10, 8'd9, 2'b10, "wr_period9");
        send(4, 2'd0, 2'b00, 8'd3, 2'b10, "wr_ch0_cmp3");
        send(4, 2'd0, 2'b01, 8'd1, 2'b10, "wr_ch0_en");
        sync(4, 600);
        capture(4, 20);
        check("edge_ch0", cap_ch[0], 64'(20'b1110000000_1110000000));
        check("edge_ps", cap_ps, 64'(20'b1000000000_1000000000));
        check("edge_ch1_off", cap_ch[1], 64'd0);

        // Extremes
        send(4, 2'd1, 2'b00, 8'd0, 2'b10, "wr_ch1_cmp0");
        send(4, 2'd1, 2'b01, 8'd1, 2'b10, "wr_ch1_en");
        send(4, 2'd2, 2'b00, 8'd10, 2'b10, "wr_ch2_cmp10");
        send(4, 2'd2, 2'b01, 8'd1, 2'b10, "wr_ch2_en");
        send(4, 2'd3, 2'b00, 8'd3, 2'b10, "wr_ch3_cmp3");
        send(4, 2'd3, 2'b01, 8'd3, 2'b10, "wr_ch3_en_pol");
        sync(4, 100);
        capture(4, 20);
        check("ext_ch0", cap_ch[0], 64'(20'b1110000000_1110000000));
        check("ext_cmp0", cap_ch[1], 64'd0);
        check("ext_cmp_over", cap_ch[2], 64'(20'hFFFFF));
        check("ext_pol", cap_ch[3], 64'(20'b0001111111_0001111111));
        send(4, 2'd3, 2'b01, 8'd2, 2'b10, "wr_ch3_dis_pol");
        sync(4, 100);
        capture(4, 10);
        check("ext_dis_pol", cap_ch[3], 64'(10'h3FF));

        // Center mode: P=4, ch0 cmp=2
        send(4, 2'd0, 2'b10, 8'd4, 2'b10, "wr_period4");
        send(4, 2'd0, 2'b11, 8'd1, 2'b10, "wr_center");
        send(4, 2'd0, 2'b00, 8'd2, 2'b10, "wr_ch0_cmp2");
        sync(4, 100);
        capture(4, 16);
        check("ctr_ch0", cap_ch[0], 64'(16'b11000001_11000001));
        check("ctr_ps", cap_ps, 64'(16'b10000000_10000000));
        check("ctr_ch2", cap_ch[2], 64'(16'hFFFF));

        // Back to edge mode, P=9, ch0 cmp=2
        send(4, 2'd0, 2'b11, 8'd0, 2'b10, "wr_edge");
        send(4, 2'd0, 2'b10, 8'd9, 2'b10, "wr_period9b");
        sync(4, 100);
        capture(4, 10);
        check("edge_ch0_cmp2", cap_ch[0], 64'(10'b1100000000));

        // Shadowing: write lands mid-period, old value holds until the next period start
        wait_ps(4, 20);
        send(4, 2'd0, 2'b00, 8'd7, 2'b10, "wr_ch0_cmp7");
        capture(4, 16);
        check("shadow_mid", cap_ch[0], 64'(16'b000000_1111111000));
        check("shadow_mid_ps", cap_ps, 64'(16'b000000_1000000000));

        // Write edge on a wrap edge: new value one period later
        wait_ps(4, 20);
        repeat (5) step();
        send(4, 2'd0, 2'b00, 8'd5, 2'b10, "wr_ch0_cmp5");
        capture(4, 21);
        check("shadow_wrap", cap_ch[0], 64'(21'b0_1111111000_1111100000));
        check("shadow_wrap_ps", cap_ps, 64'(21'b0_1000000000_1000000000));

        // Address error on the 3-channel instance
        send(3, 2'd0, 2'b10, 8'd9, 2'b10, "d3_period9");
        send(3, 2'd2, 2'b00, 8'd4, 2'b10, "d3_ch2_cmp4");
        send(3, 2'd2, 2'b01, 8'd1, 2'b10, "d3_ch2_en");
        send(3, 2'd3, 2'b00, 8'd1, 2'b01, "d3_err_cmp");
        send(3, 2'd3, 2'b01, 8'd3, 2'b01, "d3_err_ctrl");
        sync(3, 600);
        capture(3, 10);
        check("d3_ch2", cap_ch[2], 64'(10'b1111000000));
        check("d3_ch0", cap_ch[0], 64'd0);
        check("d3_ch1", cap_ch[1], 64'd0);

        // Reset in the middle of a frame payload
        begin
            logic [5:0] part;
            part = 6'b100001;
            for (int i = 5; i >= 0; i--) begin
                data4 = part[i];
                step();
            end
        end
        data4 = 1'b0;
        rst   = 1'b1;
        repeat (2) step();
        check("mid_rst_out", {58'd0, pwm4, ps4, val4}, 64'd0);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (val4 === 1'b1 || err4 === 1'b1) n++;
        end
        check("mid_rst_no_pulse", 64'(n), 64'd0);
        send(4, 2'd0, 2'b10, 8'd9, 2'b10, "post_rst_period9");
        send(4, 2'd0, 2'b00, 8'd6, 2'b10, "post_rst_cmp6");
        send(4, 2'd0, 2'b01, 8'd1, 2'b10, "post_rst_en");
        sync(4, 600);
        capture(4, 10);
        check("post_rst_ch0", cap_ch[0], 64'(10'b1111110000));
        check("post_rst_ch3", cap_ch[3], 64'd0);
        check("post_rst_ps", cap_ps, 64'(10'b1000000000));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
